// File: rtl/sine_meas.sv
// sine_meas: measures period, max, min, amplitude and DC offset of a sampled waveform.
// Latency: results and meas_valid appear 1 clk after the closing rising crossing is accepted.
// Backpressure: none; only cycles with sample_valid advance state, and idle cycles hold everything.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en                 measurement enable; low resynchronises and clears accumulators
//   sample_valid/data  signed input sample stream
//   thr                signed rising-crossing threshold
//   meas_valid         one-cycle pulse; period/max_val/min_val/amp/offset updated with it
//   timeout            one-cycle pulse when no crossing arrives within MAX_PERIOD samples
//   locked             high while measuring (between crossings)
module sine_meas #(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 20,
    parameter int HYST       = 64,
    parameter int MAX_PERIOD = 2**20-1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] thr,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] amp,
    output logic [DATA_W-1:0] offset,
    output logic              timeout,
    output logic              locked
);

    typedef enum logic {SYNC, MEAS} state_t;

    state_t                   state, state_nxt;
    logic                     armed;
    logic [CNT_W-1:0]         counter;
    logic signed [DATA_W-1:0] max_acc, min_acc;
    logic signed [DATA_W-1:0] samp_s, thr_s;

    // One extra bit keeps thr-HYST, max-min and max+min free of wrap-around.
    logic signed [DATA_W:0]   samp_ext, thr_lo;
    logic signed [DATA_W:0]   diff, sum;
    logic [DATA_W-1:0]        amp_nxt, offset_nxt;

    logic                     below, at_or_above, crossing, timeout_hit;

    assign samp_s      = $signed(sample_data);
    assign thr_s       = $signed(thr);
    assign samp_ext    = $signed({sample_data[DATA_W-1], sample_data});
    assign thr_lo      = $signed({thr[DATA_W-1], thr}) - $signed((DATA_W+1)'(HYST));
    assign below       = samp_ext < thr_lo;
    assign at_or_above = samp_s >= thr_s;

    assign crossing    = sample_valid && armed && at_or_above;
    // A crossing on the same sample takes precedence over the timeout.
    assign timeout_hit = sample_valid && (state == MEAS) && !crossing
                         && (counter == CNT_W'(MAX_PERIOD));

    // Closing results come from the accumulators, so the crossing sample is excluded.
    assign diff       = $signed({max_acc[DATA_W-1], max_acc}) - $signed({min_acc[DATA_W-1], min_acc});
    assign sum        = $signed({max_acc[DATA_W-1], max_acc}) + $signed({min_acc[DATA_W-1], min_acc});
    assign amp_nxt    = DATA_W'(diff >>> 1);
    assign offset_nxt = DATA_W'(sum >>> 1);

    assign locked = (state == MEAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = SYNC;
        end else if (crossing) begin
            state_nxt = MEAS;
        end else if (timeout_hit) begin
            state_nxt = SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed      <= 1'b0;
            counter    <= '0;
            max_acc    <= '0;
            min_acc    <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period     <= '0;
            max_val    <= '0;
            min_val    <= '0;
            amp        <= '0;
            offset     <= '0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (!en) begin
                armed   <= 1'b0;
                counter <= '0;
                max_acc <= '0;
                min_acc <= '0;
            end else if (sample_valid) begin
                if (crossing) begin
                    armed   <= 1'b0;
                    counter <= CNT_W'(1);
                    max_acc <= samp_s;
                    min_acc <= samp_s;
                    if (state == MEAS) begin
                        meas_valid <= 1'b1;
                        period     <= counter;
                        max_val    <= max_acc;
                        min_val    <= min_acc;
                        amp        <= amp_nxt;
                        offset     <= offset_nxt;
                    end
                end else if (timeout_hit) begin
                    timeout <= 1'b1;
                    armed   <= 1'b0;
                    counter <= '0;
                end else begin
                    if (below) begin
                        armed <= 1'b1;
                    end
                    // counter < MAX_PERIOD here, so the increment cannot wrap.
                    if (state == MEAS) begin
                        counter <= counter + CNT_W'(1);
                        if (samp_s > max_acc) max_acc <= samp_s;
                        if (samp_s < min_acc) min_acc <= samp_s;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_meas.sv
// Directed bench for sine_meas: two instances share stimulus (HYST=4 and HYST=64,
// both with a short MAX_PERIOD of 16) and outputs are compared against hand-derived values.
module tb_sine_meas;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               sample_valid;
    logic signed [15:0] sample_data;
    logic signed [15:0] thr;

    logic               a_mv, a_to, a_locked;
    logic [19:0]        a_period;
    logic [15:0]        a_max, a_min, a_amp, a_off;
    logic               b_mv, b_to, b_locked;
    logic [19:0]        b_period;
    logic [15:0]        b_max, b_min, b_amp, b_off;

    int n_checks = 0;
    int n_errors = 0;

    int base_pat[8] = '{100, 70, 0, -70, -100, -70, 0, 70};
    int ext_pat[4]  = '{32767, 32767, -32768, -32768};

    always #5 clk = ~clk;

    sine_meas #(.DATA_W(16), .CNT_W(20), .HYST(4), .MAX_PERIOD(16)) u_a (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
        .sample_data(sample_data), .thr(thr),
        .meas_valid(a_mv), .period(a_period), .max_val(a_max), .min_val(a_min),
        .amp(a_amp), .offset(a_off), .timeout(a_to), .locked(a_locked)
    );

    sine_meas #(.DATA_W(16), .CNT_W(20), .HYST(64), .MAX_PERIOD(16)) u_b (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
        .sample_data(sample_data), .thr(thr),
        .meas_valid(b_mv), .period(b_period), .max_val(b_max), .min_val(b_min),
        .amp(b_amp), .offset(b_off), .timeout(b_to), .locked(b_locked)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one valid sample; returns 1 time unit after the accepting edge.
    task automatic step(input int s);
        sample_data  = 16'(s);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_result(input string tag, input int per, input int mx,
                                input int mn, input int am, input int off);
        check({tag, "_period"}, int'(a_period), per);
        check({tag, "_max"}, int'($signed(a_max)), mx);
        check({tag, "_min"}, int'($signed(a_min)), mn);
        check({tag, "_amp"}, int'(a_amp), am);
        check({tag, "_offset"}, int'($signed(a_off)), off);
    endtask

    initial begin
        int mv_cnt;
        int to_cnt;
        int bad;

        rst          = 1'b1;
        en           = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        thr          = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_mv", int'(a_mv), 0);
        check("rst_to", int'(a_to), 0);
        check("rst_locked", int'(a_locked), 0);
        check_result("rst", 0, 0, 0, 0, 0);

        // Baseline: crossings at idx 6 (lock), 14 and 22 (reports)
        thr    = 16'sd0;
        mv_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(base_pat[i % 8]);
            if (a_mv) mv_cnt++;
            if (i == 5) check("base_unlocked", int'(a_locked), 0);
            if (i == 6) begin
                check("base_locked", int'(a_locked), 1);
                check("base_no_mv_first", int'(a_mv), 0);
            end
            if (i == 14 || i == 22) begin
                check("base_mv", int'(a_mv), 1);
                check_result("base", 8, 100, -100, 100, 0);
            end
        end
        check("base_mv_count", mv_cnt, 2);

        // Offset +500 with two idle cycles between valid samples
        do_reset();
        thr    = 16'sd500;
        mv_cnt = 0;
        bad    = 0;
        for (int i = 0; i < 24; i++) begin
            step(base_pat[i % 8] + 500);
            if (a_mv) mv_cnt++;
            if (i == 14 || i == 22) begin
                check("ofs_mv", int'(a_mv), 1);
                check_result("ofs", 8, 600, 400, 100, 500);
            end
            repeat (2) begin
                @(posedge clk);
                #1;
                if (a_mv) bad++;
            end
        end
        check("ofs_mv_count", mv_cnt, 2);
        check("ofs_idle_mv", bad, 0);

        // Hysteresis (HYST=64 instance): small noise must not arm
        do_reset();
        thr = 16'sd0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step((i % 2 == 0) ? -10 : 10);
            if (b_mv || b_locked) bad++;
        end
        check("hyst_noise", bad, 0);
        step(-200);
        check("hyst_armed_not_locked", int'(b_locked), 0);
        step(5);
        check("hyst_locked", int'(b_locked), 1);

        // Timeout: report once, then a flat signal for 20 samples
        do_reset();
        thr = 16'sd0;
        for (int i = 0; i < 15; i++) step(base_pat[i % 8]);
        check("to_pre_mv", int'(a_mv), 1);
        mv_cnt = 0;
        to_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            step(50);
            if (a_mv) mv_cnt++;
            if (a_to) to_cnt++;
            if (j == 14) begin
                check("to_not_yet", int'(a_to), 0);
                check("to_still_locked", int'(a_locked), 1);
            end
            if (j == 15) begin
                check("to_pulse", int'(a_to), 1);
                check("to_unlocked", int'(a_locked), 0);
            end
        end
        check("to_count", to_cnt, 1);
        check("to_no_mv", mv_cnt, 0);
        check_result("to_hold", 8, 100, -100, 100, 0);

        // Full-scale extremes, period 4
        do_reset();
        thr = 16'sd0;
        for (int i = 0; i < 11; i++) begin
            step(ext_pat[i % 4]);
            if (i == 8) begin
                check("ext_mv", int'(a_mv), 1);
                check_result("ext", 4, 32767, -32768, 32767, -1);
            end
        end

        // Reset mid-period: outputs cleared, report only after two new crossings
        do_reset();
        check("mrst_locked", int'(a_locked), 0);
        check_result("mrst", 0, 0, 0, 0, 0);
        mv_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(ext_pat[i % 4]);
            if (i < 8 && a_mv) mv_cnt++;
        end
        check("mrst_early_mv", mv_cnt, 0);
        check("mrst_mv", int'(a_mv), 1);
        check("mrst_period", int'(a_period), 4);

        // en low mid-period: resync, outputs held
        step(32767);
        step(-32768);
        en = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        check("en_locked", int'(a_locked), 0);
        check("en_mv", int'(a_mv), 0);
        check_result("en_hold", 4, 32767, -32768, 32767, -1);
        mv_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(ext_pat[i % 4]);
            if (i < 8 && a_mv) mv_cnt++;
            if (i == 4) check("en_relock", int'(a_locked), 1);
        end
        check("en_early_mv", mv_cnt, 0);
        check("en_mv_after", int'(a_mv), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
